// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, pointer type and the
// binary/Gray conversions used by both the read- and write-side controllers.
package fifo_pkg;

  localparam int DEF_PTR_WIDTH = 8;
  localparam int DEF_DEPTH     = 256;
  localparam int DEF_READ_GAP  = 4;

  // Pointer carries one extra wrap bit beyond the memory address.
  typedef logic [DEF_PTR_WIDTH:0] ptr_t;

  function automatic ptr_t bin2gray(ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(ptr_t g);
    ptr_t b;
    b[DEF_PTR_WIDTH] = g[DEF_PTR_WIDTH];
    for (int i = DEF_PTR_WIDTH - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Ports: clk, rst (async, active-high), d (async input), q (synchronised).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller (rclk domain): syncs the Gray write
// pointer, paces reads, keeps read pointers and empty/half/level flags.
// Ports: rclk, rrst, r_en, g_wptr_async in; rd_strobe, rd_addr, b_rptr,
//   g_rptr, empty, half_empty, read_error, rd_level out.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = DEF_PTR_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int READ_GAP  = DEF_READ_GAP
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 r_en,
  input  logic [PTR_WIDTH:0]   g_wptr_async,
  output logic                 rd_strobe,
  output logic [PTR_WIDTH-1:0] rd_addr,
  output logic [PTR_WIDTH:0]   b_rptr,
  output logic [PTR_WIDTH:0]   g_rptr,
  output logic                 empty,
  output logic                 half_empty,
  output logic                 read_error,
  output logic [PTR_WIDTH:0]   rd_level
);

  localparam int CW = (READ_GAP > 0) ? $clog2(READ_GAP + 1) : 1;
  localparam logic [PTR_WIDTH:0] HALF = (PTR_WIDTH+1)'(DEPTH / 2);
  localparam logic [CW-1:0] GAP = CW'(READ_GAP);

  logic [PTR_WIDTH:0] g_wptr_s;
  logic [PTR_WIDTH:0] b_wptr_s;
  logic [PTR_WIDTH:0] b_rptr_next;
  logic [PTR_WIDTH:0] g_rptr_next;
  logic [PTR_WIDTH:0] level_next;
  logic [CW-1:0]      pace_cnt;
  logic               pace_ok;
  logic               acc;

  sync_2ff #(
    .WIDTH(PTR_WIDTH + 1)
  ) u_wptr_sync (
    .clk(rclk),
    .rst(rrst),
    .d  (g_wptr_async),
    .q  (g_wptr_s)
  );

  assign b_wptr_s = gray2bin(g_wptr_s);

  // pace_cnt never exceeds GAP, so equality doubles as "not below GAP".
  assign pace_ok   = (pace_cnt == GAP);
  assign acc       = r_en & ~empty & pace_ok;
  assign rd_strobe = acc;
  assign rd_addr   = b_rptr[PTR_WIDTH-1:0];

  assign b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, acc};
  assign g_rptr_next = bin2gray(b_rptr_next);

  // Modulo subtraction; the wrap bit keeps full and empty distinct.
  assign level_next = b_wptr_s - b_rptr_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      b_rptr     <= '0;
      g_rptr     <= '0;
      pace_cnt   <= '0;
      empty      <= 1'b1;
      half_empty <= 1'b1;
      read_error <= 1'b0;
      rd_level   <= '0;
    end else begin
      b_rptr     <= b_rptr_next;
      g_rptr     <= g_rptr_next;
      empty      <= (g_rptr_next == g_wptr_s);
      half_empty <= (level_next <= HALF);
      read_error <= r_en & empty;
      rd_level   <= level_next;
      // Waiting on an empty FIFO must not bank pacing credit.
      if (acc)
        pace_cnt <= '0;
      else if (r_en & ~empty & ~pace_ok)
        pace_cnt <= pace_cnt + CW'(1);
    end
  end

endmodule
